regfile_scoreboard: RTL and testbench

Parametrised successor to the CPU register file.
- Adds NUM_READ combinational read ports, one write port and an optional same-cycle write-to-read bypass.
- Adds a per-register busy scoreboard for the pipelined core.
- Adds a reset-time clear sequencer that zeroes every register before asserting ready.
- Sits between decode/issue (reads, issue marks) and writeback (write, busy clear). Keeps the debug a0 tap.

---
 rtl/regfile_pkg.sv | 13 +
 rtl/regfile_busy_table.sv | 43 ++++
 rtl/regfile_scoreboard.sv | 87 ++++++++
 tb/tb_regfile_scoreboard.sv | 234 +++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// regfile_pkg: shared state encoding, defaults and packed-port helper for the register file
package regfile_pkg;

    typedef enum logic {CLEAR, RUN} state_t;

    localparam int A0_INDEX_DEFAULT = 10;
    localparam int NUM_READ_MAX     = 4;

    function automatic int rf_slice(input int port, input int width);
        return port * width;
    endfunction

endpackage

// File: rtl/regfile_busy_table.sv
// busy_table: per-register pending-writeback scoreboard with NUM_READ hazard lookups
module busy_table
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int NUM_READ      = 2
) (
    input  logic                              clk,
    input  logic                              rst,
    input  logic                              en_i,
    input  logic                              set_en_i,
    input  logic [ADDRESS_WIDTH-1:0]          set_addr_i,
    input  logic                              clr_en_i,
    input  logic [ADDRESS_WIDTH-1:0]          clr_addr_i,
    input  logic [NUM_READ*ADDRESS_WIDTH-1:0] lk_addr_i,
    output logic [NUM_READ-1:0]               lk_busy_o
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    logic [DEPTH-1:0] busy_q, busy_d;

    // writeback clears first so a same-cycle issue to the same register wins; x0 never busy
    always_comb begin
        busy_d = busy_q;
        if (en_i && clr_en_i) busy_d[clr_addr_i] = 1'b0;
        if (en_i && set_en_i) busy_d[set_addr_i] = 1'b1;
        busy_d[0] = 1'b0;
    end

    // scoreboard state, cleared by reset
    always_ff @(posedge clk) begin
        if (rst) busy_q <= '0;
        else     busy_q <= busy_d;
    end

    for (genvar i = 0; i < NUM_READ; i++) begin : g_lk
        logic [ADDRESS_WIDTH-1:0] a;
        assign a = lk_addr_i[rf_slice(i, ADDRESS_WIDTH) +: ADDRESS_WIDTH];
        assign lk_busy_o[i] = busy_q[a] & ~(en_i && clr_en_i && clr_addr_i == a && a != '0);
    end

endmodule

// File: rtl/regfile_scoreboard.sv
// regfile_scoreboard: multi-port register file with busy scoreboard and reset clear sequencer (option: REGFILE_BYPASS_EN)
module regfile_scoreboard
    import regfile_pkg::*;
#(
    parameter int ADDRESS_WIDTH = 5,
    parameter int DATA_WIDTH    = 32,
    parameter int NUM_READ      = 2,
    parameter int A0_INDEX      = A0_INDEX_DEFAULT
) (
    input  logic                              clk,
    input  logic                              rst,
    output logic                              ready,
    input  logic [NUM_READ*ADDRESS_WIDTH-1:0] rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0]    rd_data,
    output logic [NUM_READ-1:0]               rd_busy,
    input  logic                              wr_en,
    input  logic [ADDRESS_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]             wr_data,
    input  logic                              iss_en,
    input  logic [ADDRESS_WIDTH-1:0]          iss_addr,
    output logic [DATA_WIDTH-1:0]             a0
);

    localparam int DEPTH = 2 ** ADDRESS_WIDTH;

    state_t                   state_q;
    logic [ADDRESS_WIDTH-1:0] cnt_q;
    logic                     ready_q;
    logic [DATA_WIDTH-1:0]    mem_q [DEPTH];
    logic                     wr_ok;
    logic [NUM_READ-1:0]      busy_raw;

    assign wr_ok = ready_q && wr_en && wr_addr != '0;

    // clear sequencer: walk every index once, then hold in RUN until reset
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= CLEAR;
            cnt_q   <= '0;
            ready_q <= 1'b0;
        end else if (state_q == CLEAR) begin
            cnt_q <= cnt_q + 1'b1;
            if (cnt_q == '1) begin
                state_q <= RUN;
                ready_q <= 1'b1;
            end
        end
    end

    // data array: zeroed by the sequencer, then written back from the pipeline
    always_ff @(posedge clk) begin
        if (!rst && state_q == CLEAR) mem_q[cnt_q] <= '0;
        else if (!rst && wr_ok)       mem_q[wr_addr] <= wr_data;
    end

    busy_table #(
        .ADDRESS_WIDTH(ADDRESS_WIDTH),
        .NUM_READ     (NUM_READ)
    ) u_busy (
        .clk       (clk),
        .rst       (rst),
        .en_i      (ready_q),
        .set_en_i  (iss_en),
        .set_addr_i(iss_addr),
        .clr_en_i  (wr_en),
        .clr_addr_i(wr_addr),
        .lk_addr_i (rd_addr),
        .lk_busy_o (busy_raw)
    );

    for (genvar i = 0; i < NUM_READ; i++) begin : g_rd
        logic [ADDRESS_WIDTH-1:0] a;
        logic [DATA_WIDTH-1:0]    v;
        assign a = rd_addr[rf_slice(i, ADDRESS_WIDTH) +: ADDRESS_WIDTH];
`ifdef REGFILE_BYPASS_EN
        assign v = (wr_ok && wr_addr == a) ? wr_data : mem_q[a];
`else
        assign v = mem_q[a];
`endif
        assign rd_data[rf_slice(i, DATA_WIDTH) +: DATA_WIDTH] = (ready_q && a != '0) ? v : '0;
    end

    assign ready   = ready_q;
    assign rd_busy = ready_q ? busy_raw : '0;
    assign a0      = ready_q ? mem_q[ADDRESS_WIDTH'(A0_INDEX)] : '0;

endmodule

// File: tb/tb_regfile_scoreboard.sv
// tb_regfile_scoreboard: directed and randomized checks of regfile_scoreboard against a reference model
module tb_regfile_scoreboard;
    import regfile_pkg::*;

    localparam int AW    = 5;
    localparam int DW    = 32;
    localparam int NR    = 2;
    localparam int DEPTH = 2 ** AW;
    localparam int A0    = A0_INDEX_DEFAULT;

    logic           clk = 1'b0;
    logic           rst = 1'b1;
    logic           ready;
    logic [AW-1:0]  ra [NR];
    logic [NR*AW-1:0] rd_addr;
    logic [NR*DW-1:0] rd_data;
    logic [NR-1:0]  rd_busy;
    logic           wr_en = 1'b0;
    logic [AW-1:0]  wr_addr = '0;
    logic [DW-1:0]  wr_data = '0;
    logic           iss_en = 1'b0;
    logic [AW-1:0]  iss_addr = '0;
    logic [DW-1:0]  a0;

    assign rd_addr = {ra[1], ra[0]};

    always #5 clk = ~clk;

    regfile_scoreboard #(
        .ADDRESS_WIDTH(AW),
        .DATA_WIDTH   (DW),
        .NUM_READ     (NR),
        .A0_INDEX     (A0)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .ready   (ready),
        .rd_addr (rd_addr),
        .rd_data (rd_data),
        .rd_busy (rd_busy),
        .wr_en   (wr_en),
        .wr_addr (wr_addr),
        .wr_data (wr_data),
        .iss_en  (iss_en),
        .iss_addr(iss_addr),
        .a0      (a0)
    );

    int tests = 0;
    int fails = 0;

    logic [DW-1:0] mreg [DEPTH];
    bit            mbusy [DEPTH];
    bit            mready = 1'b0;
    int            ccnt = 0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        tests++;
        assert (obs === exp) else begin
            fails++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [DW-1:0] exp_data(input int p);
        logic [AW-1:0] a = ra[p];
        if (!mready || a == 0) return '0;
`ifdef REGFILE_BYPASS_EN
        if (wr_en && wr_addr == a) return wr_data;
`endif
        return mreg[a];
    endfunction

    function automatic logic exp_busy(input int p);
        logic [AW-1:0] a = ra[p];
        return mready && a != 0 && mbusy[a] && !(wr_en && wr_addr == a);
    endfunction

    task automatic check_model(input string tag);
        for (int p = 0; p < NR; p++) begin
            chk({tag, "_data"}, rd_data[p*DW +: DW], exp_data(p));
            chk({tag, "_busy"}, 32'(rd_busy[p]), 32'(exp_busy(p)));
        end
        chk({tag, "_ready"}, 32'(ready), 32'(mready));
        chk({tag, "_a0"}, a0, mready ? mreg[A0] : '0);
    endtask

    task automatic model_edge();
        if (rst) begin
            mready = 1'b0;
            ccnt   = 0;
            for (int k = 0; k < DEPTH; k++) mbusy[k] = 1'b0;
        end else if (!mready) begin
            mreg[ccnt] = '0;
            ccnt++;
            if (ccnt == DEPTH) mready = 1'b1;
        end else begin
            if (wr_en && wr_addr != 0) begin
                mreg[wr_addr]  = wr_data;
                mbusy[wr_addr] = 1'b0;
            end
            if (iss_en && iss_addr != 0) mbusy[iss_addr] = 1'b1;
        end
    endtask

    task automatic cyc(input string tag);
        #1 check_model(tag);
        @(posedge clk);
        model_edge();
        @(negedge clk);
    endtask

    task automatic clear_run(input string tag);
        for (int k = 0; k < DEPTH; k++) begin
            chk({tag, "_ready_low"}, 32'(ready), 32'h0);
            cyc(tag);
        end
        chk({tag, "_ready_high"}, 32'(ready), 32'h1);
    endtask

    initial begin
        for (int k = 0; k < DEPTH; k++) begin
            mreg[k]  = '0;
            mbusy[k] = 1'b0;
        end
        ra[0] = '0;
        ra[1] = '0;
        @(posedge clk);
        model_edge();
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(ready), 32'h0);
        chk("rst_busy", 32'(rd_busy), 32'h0);
        chk("rst_data", rd_data[DW-1:0], 32'h0);

        wr_en = 1'b1; wr_addr = 5'd3; wr_data = 32'h11;
        clear_run("clear");
        wr_en = 1'b0; ra[0] = 5'd3;
        #1 chk("clear_wr_ignored", rd_data[DW-1:0], 32'h0);
        cyc("post_clear");

        wr_en = 1'b1; wr_addr = 5'd5; wr_data = 32'hDEAD;
        cyc("wr5");
        wr_en = 1'b0; ra[0] = 5'd5;
        #1 chk("reg5_written", rd_data[DW-1:0], 32'hDEAD);
        rst = 1'b1;
        cyc("rst_pulse");
        rst = 1'b0;
        clear_run("reclear");
        #1 chk("reg5_cleared", rd_data[DW-1:0], 32'h0);

        wr_en = 1'b1; wr_addr = 5'd10; wr_data = 32'h12345678;
        cyc("wr10");
        chk("a0_next", a0, 32'h12345678);
        wr_addr = 5'd0; wr_data = 32'hFFFFFFFF;
        cyc("wr0");
        wr_en = 1'b0; ra[0] = 5'd0;
        #1;
        chk("x0_data", rd_data[DW-1:0], 32'h0);
        chk("x0_busy", 32'(rd_busy[0]), 32'h0);
        chk("a0_hold", a0, 32'h12345678);
        cyc("x0");

        wr_en = 1'b1; wr_addr = 5'd7; wr_data = 32'h77;
        cyc("wr7_old");
        wr_data = 32'hCAFEF00D; ra[1] = 5'd7;
`ifdef REGFILE_BYPASS_EN
        #1 chk("bypass_same", rd_data[2*DW-1:DW], 32'hCAFEF00D);
`else
        #1 chk("bypass_same", rd_data[2*DW-1:DW], 32'h77);
`endif
        cyc("wr7_new");
        wr_en = 1'b0;
        #1 chk("bypass_next", rd_data[2*DW-1:DW], 32'hCAFEF00D);
        cyc("rd7");

        iss_en = 1'b1; iss_addr = 5'd4;
        cyc("iss4");
        iss_en = 1'b0; ra[0] = 5'd4;
        #1 chk("busy4_set", 32'(rd_busy[0]), 32'h1);
        wr_en = 1'b1; wr_addr = 5'd4; wr_data = 32'h44;
        #1 chk("busy4_wb_cycle", 32'(rd_busy[0]), 32'h0);
        cyc("wb4");
        wr_en = 1'b0;
        #1 chk("busy4_after", 32'(rd_busy[0]), 32'h0);
        cyc("idle4");

        iss_en = 1'b1; iss_addr = 5'd9;
        cyc("iss9");
        wr_en = 1'b1; wr_addr = 5'd9; wr_data = 32'h99;
        cyc("iss_wb9");
        iss_en = 1'b0; wr_en = 1'b0; ra[0] = 5'd9;
        #1 chk("busy9_kept", 32'(rd_busy[0]), 32'h1);
        cyc("chk9");

        iss_en = 1'b1; iss_addr = 5'd2;
        cyc("iss2");
        iss_addr = 5'd3;
        cyc("iss3");
        iss_en = 1'b0; ra[0] = 5'd2; ra[1] = 5'd3;
        #1 chk("busy23", 32'(rd_busy), 32'h3);
        rst = 1'b1;
        cyc("midrun_rst");
        rst = 1'b0;
        #1;
        chk("midrun_ready", 32'(ready), 32'h0);
        chk("midrun_busy_vec", dut.u_busy.busy_q, 32'h0);
        clear_run("midrun_clear");
        ra[0] = 5'd7; ra[1] = 5'd2;
        #1;
        chk("midrun_reg7", rd_data[DW-1:0], 32'h0);
        chk("midrun_busy2", 32'(rd_busy[1]), 32'h0);
        chk("midrun_a0", a0, 32'h0);
        cyc("midrun_rd");

        for (int n = 0; n < 600; n++) begin
            rst      = ($urandom_range(0, 149) == 0);
            wr_en    = 1'($urandom_range(0, 1));
            wr_addr  = AW'($urandom_range(0, 7));
            wr_data  = $urandom;
            iss_en   = 1'($urandom_range(0, 1));
            iss_addr = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, 7));
            ra[0]    = ($urandom_range(0, 3) == 0) ? wr_addr : AW'($urandom_range(0, 15));
            ra[1]    = ($urandom_range(0, 3) == 0) ? ra[0] : AW'($urandom_range(0, 15));
            cyc("rand");
        end
        rst = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
